efuse_load_ctrl: RTL
====================

EFUSE_LOAD_CTRL -- requirements
Module: efuse_load_ctrl

Interface
REQ-001 Parameter NR, 64, bits per efuse read segment.
REQ-002 Parameter RSEL, 4, number of segments (256/NR).
REQ-003 Parameter PWRUP_WAIT, 16, cycles between reset release and the first read.
REQ-004 Parameter TIMEOUT, 1023, maximum cycles allowed per segment read before error.
REQ-005 clk  input  1  clock (6.5 MHz).
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 reload  input  1  single-cycle pulse requesting a full shadow reload.
REQ-008 sw_req  input  1  software read request; level, held until sw_ack.
REQ-009 sw_sel  input  $clog2(RSEL)  software segment select; stable while sw_req is high.
REQ-010 sw_ack  output  1  one-cycle pulse; sw_rdata is valid in the same cycle.
REQ-011 sw_rdata  output  NR  data of the last completed software read.
REQ-012 shadow_data  output  NR*RSEL  shadow copy; segment s occupies bits [s*NR +: NR].
REQ-013 load_done  output  1  high while the shadow holds a complete autoload.
REQ-014 load_err  output  1  sticky timeout flag; cleared only by reset or an accepted reload.
REQ-015 rd_start  output  1  one-cycle start pulse to the read engine.
REQ-016 rd_sel  output  $clog2(RSEL)  segment select to the read engine; held from rd_start until completion.
REQ-017 rd_done  input  1  engine done level; the engine clears it one cycle after rd_start.
REQ-018 rd_busy  input  1  engine busy level.
REQ-019 rd_data  input  NR  engine read data; valid while rd_done is high.

Function
REQ-020 The FSM SHALL have states PWRUP, AUTO_REQ, AUTO_WAIT, READY, SW_REQ, SW_WAIT.
- PWRUP: counts PWRUP_WAIT cycles, then enters AUTO_REQ with seg=0.
- AUTO_REQ: rd_start=1 and rd_sel=seg for exactly one cycle, then enters AUTO_WAIT.
- AUTO_WAIT: on rd_done & ~rd_busy, writes rd_data into shadow segment seg. If seg==RSEL-1 it sets load_done and enters READY; otherwise seg increments and it enters AUTO_REQ.
- READY: an accepted reload clears load_done and load_err, leaves shadow_data unchanged, and enters AUTO_REQ with seg=0. Otherwise, sw_req enters SW_REQ.
- SW_REQ: rd_start=1 and rd_sel=sw_sel for one cycle, then enters SW_WAIT.
- SW_WAIT: on rd_done & ~rd_busy, latches rd_data into sw_rdata, pulses sw_ack, and returns to READY. shadow_data is not modified.
REQ-021 The completion condition SHALL NOT be sampled in the cycle directly after rd_start; this masks a stale rd_done.
REQ-022 A per-read timeout counter SHALL clear on every rd_start. If it reaches TIMEOUT while in a WAIT state:
- load_err is set.
- In AUTO_WAIT, the segment is skipped and its shadow segment is left unchanged.
- In SW_WAIT, sw_ack pulses with sw_rdata = 0.
REQ-023 When reload and sw_req arrive in the same READY cycle, reload SHALL win; sw_req stays pending and is served after the autoload completes.
REQ-024 reload arriving outside READY SHALL be ignored.
REQ-025 sw_req arriving during autoload SHALL be held pending and is not acknowledged until the autoload completes.
REQ-026 The block SHALL never have more than one read outstanding; rd_start SHALL NOT pulse while rd_busy=1.
REQ-027 The segment counter SHALL be $clog2(RSEL) bits wide and SHALL NOT wrap past RSEL-1.

Reset
REQ-028 Reset SHALL put the FSM in PWRUP and clear all counters.
REQ-029 Reset SHALL drive these outputs to 0: sw_ack, sw_rdata, shadow_data, load_done, load_err, rd_start, rd_sel.
REQ-030 A reset asserted mid-read SHALL abandon the transfer; after release, the block restarts the full PWRUP sequence.

Configuration
REQ-031 With EFUSE_SW_READ_EN defined, the SW_REQ/SW_WAIT path and sw_rdata logic SHALL be present.
REQ-032 With EFUSE_SW_READ_EN undefined:
- The SW_REQ/SW_WAIT states are absent.
- sw_ack and sw_rdata are tied to 0.
- sw_req is ignored.
- The ports remain present.

Structure
REQ-033 A shared package efuse_pkg SHALL hold the FSM state enum, NR, RSEL and the default PWRUP_WAIT and TIMEOUT constants.
REQ-034 The timeout counter SHALL be implemented as sub-module efuse_tmo_cnt (clear, enable, limit, expired).

Verification
REQ-035 Reset release with an engine model at 40 cycles per read -> rd_start pulses at reset+16 with sel 0, 1, 2, 3; load_done rises after the 4th rd_done; shadow_data equals the concatenated model data.
REQ-036 sw_req=1, sw_sel=2 in READY -> one rd_start with rd_sel=2; sw_ack pulses once; sw_rdata equals segment-2 data; shadow_data is unchanged.
REQ-037 reload and sw_req in the same cycle -> four autoload reads complete first, then one software read; sw_ack pulses once.
REQ-038 Engine never asserts rd_done on segment 1 -> load_err sets 1023 cycles after that rd_start; segments 2 and 3 still load; load_done=1.
REQ-039 rst_n asserted during the segment-2 read -> all outputs return to 0; after release the sequence restarts at seg 0 following 16 cycles.
REQ-040 Build without EFUSE_SW_READ_EN, sw_req held high -> no software rd_start, sw_ack stays 0, autoload is unaffected.

Source files
------------

// File: rtl/efuse_pkg.sv
// Shared sizing constants and FSM state encoding for the efuse shadow loader.
// The SW_REQ/SW_WAIT encodings exist only when EFUSE_SW_READ_EN is defined.
package efuse_pkg;

  localparam int unsigned NR         = 64;
  localparam int unsigned RSEL       = 256 / NR;
  localparam int unsigned PWRUP_WAIT = 16;
  localparam int unsigned TIMEOUT    = 1023;

  typedef logic [2:0] efuse_state_t;

  localparam efuse_state_t StPwrup    = 3'd0;
  localparam efuse_state_t StAutoReq  = 3'd1;
  localparam efuse_state_t StAutoWait = 3'd2;
  localparam efuse_state_t StReady    = 3'd3;
`ifdef EFUSE_SW_READ_EN
  localparam efuse_state_t StSwReq    = 3'd4;
  localparam efuse_state_t StSwWait   = 3'd5;
`endif

endpackage

// File: rtl/efuse_tmo_cnt.sv
// Per-read timeout counter: clear restarts the count, expired flags the cycle whose
// closing edge completes `limit` cycles since the clearing cycle.
module efuse_tmo_cnt #(
  parameter int unsigned Width = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] limit,
  output logic             expired
);

  logic [Width-1:0] cnt_d, cnt_q;

  // The clearing cycle itself counts as the first elapsed cycle.
  assign expired = enable && !clear && (cnt_q + Width'(1) == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = Width'(1);
    end else if (enable && cnt_q != limit) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/efuse_load_ctrl.sv
// Efuse shadow loader: autoloads all segments after power-up or reload, and optionally
// serves single-segment software reads when EFUSE_SW_READ_EN is defined.
module efuse_load_ctrl #(
  parameter int unsigned NR         = efuse_pkg::NR,
  parameter int unsigned RSEL       = efuse_pkg::RSEL,
  parameter int unsigned PWRUP_WAIT = efuse_pkg::PWRUP_WAIT,
  parameter int unsigned TIMEOUT    = efuse_pkg::TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    reload,
  input  logic                    sw_req,
  input  logic [$clog2(RSEL)-1:0] sw_sel,
  output logic                    sw_ack,
  output logic [NR-1:0]           sw_rdata,
  output logic [NR*RSEL-1:0]      shadow_data,
  output logic                    load_done,
  output logic                    load_err,
  output logic                    rd_start,
  output logic [$clog2(RSEL)-1:0] rd_sel,
  input  logic                    rd_done,
  input  logic                    rd_busy,
  input  logic [NR-1:0]           rd_data
);
  import efuse_pkg::*;

  localparam int unsigned SelW = $clog2(RSEL);
  localparam int unsigned PwrW = $clog2(PWRUP_WAIT + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [SelW-1:0] LastSeg = SelW'(RSEL - 1);

  efuse_state_t       state_d, state_q;
  logic [PwrW-1:0]    pwr_cnt_d, pwr_cnt_q;
  logic [SelW-1:0]    seg_d, seg_q;
  logic [SelW-1:0]    rd_sel_d, rd_sel_q;
  logic [NR*RSEL-1:0] shadow_d, shadow_q;
  logic               load_done_d, load_done_q;
  logic               load_err_d, load_err_q;
  logic               skip_q;
  logic               req_state, in_wait, rd_fin, tmo_exp;

`ifdef EFUSE_SW_READ_EN
  logic          sw_ack_d, sw_ack_q;
  logic [NR-1:0] sw_rdata_d, sw_rdata_q;

  assign req_state = (state_q == StAutoReq) || (state_q == StSwReq);
  assign in_wait   = (state_q == StAutoWait) || (state_q == StSwWait);
  assign sw_ack    = sw_ack_q;
  assign sw_rdata  = sw_rdata_q;
`else
  logic unused_sw;

  assign req_state = (state_q == StAutoReq);
  assign in_wait   = (state_q == StAutoWait);
  assign sw_ack    = 1'b0;
  assign sw_rdata  = '0;
  assign unused_sw = ^{sw_req, sw_sel};
`endif

  // Never launch into a busy engine; the REQ state simply holds until it frees up.
  assign rd_start    = req_state && !rd_busy;
  assign rd_sel      = rd_sel_q;
  assign shadow_data = shadow_q;
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;

  // skip_q masks the stale rd_done still visible in the cycle after rd_start.
  assign rd_fin = rd_done && !rd_busy && !skip_q;

  efuse_tmo_cnt #(
    .Width (TmoW)
  ) u_tmo_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (rd_start),
    .enable  (in_wait),
    .limit   (TmoW'(TIMEOUT)),
    .expired (tmo_exp)
  );

  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = pwr_cnt_q;
    seg_d       = seg_q;
    rd_sel_d    = rd_sel_q;
    shadow_d    = shadow_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;
`ifdef EFUSE_SW_READ_EN
    sw_ack_d    = 1'b0;
    sw_rdata_d  = sw_rdata_q;
`endif
    case (state_q)
      StPwrup: begin
        if (pwr_cnt_q == PwrW'(PWRUP_WAIT - 1)) begin
          seg_d    = '0;
          rd_sel_d = '0;
          state_d  = StAutoReq;
        end else begin
          pwr_cnt_d = pwr_cnt_q + PwrW'(1);
        end
      end
      StAutoReq: begin
        if (!rd_busy) state_d = StAutoWait;
      end
      StAutoWait: begin
        if (rd_fin || tmo_exp) begin
          // A timed-out segment keeps its previous shadow contents.
          if (rd_fin) begin
            shadow_d[seg_q*NR +: NR] = rd_data;
          end else begin
            load_err_d = 1'b1;
          end
          if (seg_q == LastSeg) begin
            load_done_d = 1'b1;
            state_d     = StReady;
          end else begin
            seg_d    = seg_q + SelW'(1);
            rd_sel_d = seg_q + SelW'(1);
            state_d  = StAutoReq;
          end
        end
      end
      StReady: begin
        if (reload) begin
          load_done_d = 1'b0;
          load_err_d  = 1'b0;
          seg_d       = '0;
          rd_sel_d    = '0;
          state_d     = StAutoReq;
`ifdef EFUSE_SW_READ_EN
        // sw_req is still high during the ack cycle; wait for the requester to drop it.
        end else if (sw_req && !sw_ack_q) begin
          rd_sel_d = sw_sel;
          state_d  = StSwReq;
`endif
        end
      end
`ifdef EFUSE_SW_READ_EN
      StSwReq: begin
        if (!rd_busy) state_d = StSwWait;
      end
      StSwWait: begin
        if (rd_fin) begin
          sw_rdata_d = rd_data;
          sw_ack_d   = 1'b1;
          state_d    = StReady;
        end else if (tmo_exp) begin
          sw_rdata_d = '0;
          sw_ack_d   = 1'b1;
          load_err_d = 1'b1;
          state_d    = StReady;
        end
      end
`endif
      default: state_d = StPwrup;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StPwrup;
      pwr_cnt_q   <= '0;
      seg_q       <= '0;
      rd_sel_q    <= '0;
      shadow_q    <= '0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      seg_q       <= seg_d;
      rd_sel_q    <= rd_sel_d;
      shadow_q    <= shadow_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      skip_q      <= rd_start;
    end
  end

`ifdef EFUSE_SW_READ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_ack_q   <= 1'b0;
      sw_rdata_q <= '0;
    end else begin
      sw_ack_q   <= sw_ack_d;
      sw_rdata_q <= sw_rdata_d;
    end
  end
`endif

endmodule
